// File: rtl/noc_pkg.sv
// Shared flit encodings and framing-FSM states for the NoC router input ports.
package noc_pkg;

   localparam logic [2:0] FLIT_NONE   = 3'b000;
   localparam logic [2:0] FLIT_HEADER = 3'b001;
   localparam logic [2:0] FLIT_BODY   = 3'b010;
   localparam logic [2:0] FLIT_TAIL   = 3'b100;

   localparam int LEN_W = 12;

   // HDR: packet framed but its own header not yet forwarded; PKT: header forwarded.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HDR  = 2'd1,
      ST_PKT  = 2'd2
   } pkt_state_t;

   function automatic logic is_header(input logic [2:0] id);
      return id == FLIT_HEADER;
   endfunction

endpackage

// File: rtl/flit_fifo.sv
// Synchronous flit FIFO with registered pointers and occupancy count; head is read combinationally.
module flit_fifo #(
   parameter int WIDTH = 35,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_word,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head_word
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   count;
   logic             do_push;
   logic             do_pop;

   assign full      = (count == (PTR_W + 1)'(DEPTH));
   assign empty     = (count == '0);
   // A full FIFO refuses pushes even when a pop frees a slot in the same cycle.
   assign do_push   = push && !full;
   assign do_pop    = pop && !empty;
   assign head_word = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_word;
   end

endmodule

// File: rtl/input_port_buffer.sv
// Router input port: flit FIFO, packet-framing FSM driving req, length latch and registered output.
module input_port_buffer
   import noc_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [2:0]        in_flit_id,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   input  logic              grant,
   output logic              req,
   output logic [2:0]        flit_id,
   output logic [LEN_W-1:0]  length,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic              err
);

   localparam int WORD_W = 3 + DATA_W;

   logic              full;
   logic              empty;
   logic              push;
   logic              fifo_pop;
   logic              fwd_pop;
   logic              drop;
   logic              err_nxt;
   logic [WORD_W-1:0] head_word;
   logic [2:0]        head_id;
   logic [DATA_W-1:0] head_data;
   logic              head_is_hdr;

   pkt_state_t        state;
   pkt_state_t        state_nxt;
   logic [LEN_W-1:0]  len_q;
   logic              vld_p1;
   logic              err_p1;
   logic [DATA_W-1:0] data_p1;

   assign in_ready = !full;
   assign push     = in_valid && !full;
   assign fifo_pop = fwd_pop || drop;

   flit_fifo #(
      .WIDTH (WORD_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_word ({in_flit_id, in_data}),
      .pop       (fifo_pop),
      .full      (full),
      .empty     (empty),
      .head_word (head_word)
   );

   assign head_id     = head_word[WORD_W-1 -: 3];
   assign head_data   = head_word[DATA_W-1:0];
   assign head_is_hdr = !empty && is_header(head_id);

   assign req     = (state != ST_IDLE);
   assign flit_id = empty ? FLIT_NONE : head_id;
   assign length  = head_is_hdr ? head_data[LEN_W-1:0] : len_q;

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      fwd_pop   = 1'b0;
      drop      = 1'b0;
      err_nxt   = 1'b0;
      case (state)
         ST_IDLE: begin
            // Orphan body/tail flits are discarded without waiting for a grant.
            if (!empty) begin
               if (is_header(head_id)) begin
                  state_nxt = ST_HDR;
               end else begin
                  drop    = 1'b1;
                  err_nxt = 1'b1;
               end
            end
         end
         ST_HDR: begin
            if (grant && !empty) begin
               fwd_pop   = 1'b1;
               state_nxt = ST_PKT;
            end
         end
         ST_PKT: begin
            if (grant && !empty) begin
               fwd_pop = 1'b1;
               if (head_id == FLIT_TAIL) state_nxt = ST_IDLE;
               else if (is_header(head_id)) err_nxt = 1'b1;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Stage p1: popped flit and error pulse, one cycle after the pop decision.
   always_ff @(posedge clk) begin
      if (rst) begin
         len_q  <= '0;
         vld_p1 <= 1'b0;
         err_p1 <= 1'b0;
      end else begin
         if (head_is_hdr) len_q <= head_data[LEN_W-1:0];
         vld_p1 <= fwd_pop;
         err_p1 <= err_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (fwd_pop) data_p1 <= head_data;
   end

   assign out_valid = vld_p1;
   assign out_data  = data_p1;
   assign err       = err_p1;

endmodule
